// File: rtl/eth_fcs_insert_pkg.sv
// Shared types and constants for the Ethernet FCS inserter and its CRC-32 engine.
// The residue constant is the register value left after running the CRC over a good frame including its FCS.
package eth_fcs_insert_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_PAD,
        ST_FCS
    } state_t;

    localparam int          CNT_W       = 11;
    localparam logic [31:0] CRC_INIT    = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC_RESIDUE = 32'hC704_DD7B;
    localparam logic [31:0] CRC_POLY    = 32'h04C1_1DB7;

    // MSB-first register; data bit 0 is the first bit on the wire, so it is shifted in first.
    function automatic logic [31:0] crc32_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c;
        for (int j = 0; j < 8; j++) begin
            r = {r[30:0], 1'b0} ^ ((r[31] ^ d[j]) ? CRC_POLY : 32'h0);
        end
        return r;
    endfunction

endpackage

// File: rtl/eth_fcs_insert_crc.sv
// 8-bit parallel IEEE 802.3 CRC-32: one byte per enabled cycle, rst (re)initialises.
// Crc is the registered value, CrcNext the combinational value after absorbing data_in.
module crc
    import eth_fcs_insert_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  data_in,
    input  logic        enable,
    output logic [31:0] Crc,
    output logic [31:0] CrcNext
);

    logic [31:0] r_crc;

    assign CrcNext = crc32_byte(r_crc, data_in);
    assign Crc     = r_crc;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_crc <= CRC_INIT;
        end else if (enable) begin
            r_crc <= CrcNext;
        end
    end

endmodule

// File: rtl/eth_fcs_insert.sv
// Pads short frames with zeros and appends the CRC-32 FCS; payload passes through with zero latency.
// Backpressure: m_ready stalls everything; s_ready follows m_ready in IDLE/DATA and is low during PAD/FCS.
module eth_fcs_insert
    import eth_fcs_insert_pkg::*;
#(
    parameter int MIN_LEN = 60,
    parameter bit PAD_EN  = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] s_data,
    input  logic       s_valid,
    input  logic       s_last,
    output logic       s_ready,
    output logic [7:0] m_data,
    output logic       m_valid,
    output logic       m_last,
    input  logic       m_ready
);

    localparam logic [CNT_W-1:0] MIN_LEN_C = CNT_W'(MIN_LEN);

    state_t           r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt, w_cnt_inc;
    logic [1:0]       r_k, w_k_nxt;
    logic [31:0]      w_crc;
    logic [31:0]      w_crc_next_unused;
    logic [7:0]       w_crc_byte, w_fcs_byte;
    logic             w_crc_init, w_crc_en;

    crc u_crc (
        .clk     (clk),
        .rst     (w_crc_init),
        .data_in (m_data),
        .enable  (w_crc_en),
        .Crc     (w_crc),
        .CrcNext (w_crc_next_unused)
    );

    // Register is sent most significant byte first, each byte bit-reversed and inverted.
    always_comb begin
        case (r_k)
            2'd0:    w_crc_byte = w_crc[31:24];
            2'd1:    w_crc_byte = w_crc[23:16];
            2'd2:    w_crc_byte = w_crc[15:8];
            default: w_crc_byte = w_crc[7:0];
        endcase
        for (int i = 0; i < 8; i++) begin
            w_fcs_byte[i] = ~w_crc_byte[7-i];
        end
    end

    assign w_crc_en = m_valid && m_ready && (r_state != ST_FCS);

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_k_nxt     = r_k;
        w_cnt_inc   = (r_cnt < MIN_LEN_C) ? r_cnt + 1'b1 : r_cnt;
        s_ready     = 1'b0;
        m_valid     = 1'b0;
        m_data      = 8'h00;
        m_last      = 1'b0;
        w_crc_init  = 1'b0;
        case (r_state)
            ST_IDLE, ST_DATA: begin
                m_data  = s_data;
                m_valid = s_valid;
                s_ready = m_ready;
                if (s_valid && m_ready) begin
                    w_cnt_nxt = w_cnt_inc;
                    if (!s_last) begin
                        w_state_nxt = ST_DATA;
                    end else if (PAD_EN && (w_cnt_inc < MIN_LEN_C)) begin
                        w_state_nxt = ST_PAD;
                    end else begin
                        w_state_nxt = ST_FCS;
                    end
                end
            end
            ST_PAD: begin
                m_valid = 1'b1;
                if (m_ready) begin
                    w_cnt_nxt = w_cnt_inc;
                    if (w_cnt_inc >= MIN_LEN_C) begin
                        w_state_nxt = ST_FCS;
                    end
                end
            end
            ST_FCS: begin
                m_valid = 1'b1;
                m_data  = w_fcs_byte;
                m_last  = (r_k == 2'd3);
                if (m_ready) begin
                    if (r_k == 2'd3) begin
                        w_state_nxt = ST_IDLE;
                        w_cnt_nxt   = '0;
                        w_k_nxt     = 2'd0;
                        w_crc_init  = 1'b1;
                    end else begin
                        w_k_nxt = r_k + 2'd1;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
        // Reset looks like IDLE on the ports even if a frame was mid-flight.
        if (rst) begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = '0;
            w_k_nxt     = 2'd0;
            w_crc_init  = 1'b1;
            m_data      = s_data;
            m_valid     = s_valid;
            s_ready     = m_ready;
            m_last      = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_k     <= 2'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_k     <= w_k_nxt;
        end
    end

endmodule

// File: tb/tb_eth_fcs_insert.sv
// Directed bench: two instances (PAD_EN=0 and PAD_EN=1), reflected-CRC reference model for FCS values.
module tb_eth_fcs_insert;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] s_data;
    logic [1:0] s_valid;
    logic       s_last;
    logic       m_ready;

    logic       s_ready0, m_valid0, m_last0;
    logic [7:0] m_data0;
    logic       s_ready1, m_valid1, m_last1;
    logic [7:0] m_data1;

    int sel;
    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] tx_pay [0:1599];
    logic [7:0] rx_dat [$];
    logic       rx_last[$];

    wire [7:0] o_dat  = (sel == 1) ? m_data1  : m_data0;
    wire       o_vld  = (sel == 1) ? m_valid1 : m_valid0;
    wire       o_last = (sel == 1) ? m_last1  : m_last0;
    wire       o_srdy = (sel == 1) ? s_ready1 : s_ready0;

    always #5 clk = ~clk;

    eth_fcs_insert #(.MIN_LEN(60), .PAD_EN(1'b0)) u_dut0 (
        .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid[0]), .s_last(s_last),
        .s_ready(s_ready0), .m_data(m_data0), .m_valid(m_valid0), .m_last(m_last0), .m_ready(m_ready)
    );

    eth_fcs_insert #(.MIN_LEN(60), .PAD_EN(1'b1)) u_dut1 (
        .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid[1]), .s_last(s_last),
        .s_ready(s_ready1), .m_data(m_data1), .m_valid(m_valid1), .m_last(m_last1), .m_ready(m_ready)
    );

    // Reference: LSB-first (reflected) CRC-32, FCS = ~crc sent low byte first.
    function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c ^ {24'h0, d};
        for (int j = 0; j < 8; j++) r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
        return r;
    endfunction

    function automatic logic [31:0] model_fcs(input int n, input int total);
        logic [31:0] c;
        c = 32'hFFFF_FFFF;
        for (int i = 0; i < total; i++) c = crc_step(c, (i < n) ? tx_pay[i] : 8'h00);
        return ~c;
    endfunction

    // Called and returns at posedge+1; pushes every accepted output byte into rx_*.
    task automatic run_frame(input int s, input int len, input bit rnd, input int max_out, output bit to);
        int idx;
        int cyc;
        bit done;
        idx = 0; cyc = 0; done = 0; to = 0;
        sel = s;
        while (!done) begin
            s_data  = (idx < len) ? tx_pay[idx] : 8'h00;
            s_last  = (idx == len - 1);
            s_valid = 2'b00;
            if (idx < len && (!rnd || $urandom_range(3) != 0)) s_valid[s] = 1'b1;
            m_ready = !rnd || ($urandom_range(2) != 0);
            @(negedge clk);
            if (s_valid[s] && o_srdy) idx++;
            if (o_vld && m_ready) begin
                rx_dat.push_back(o_dat);
                rx_last.push_back(o_last);
                if (o_last || rx_dat.size() >= max_out) done = 1;
            end
            cyc++;
            if (cyc >= 20000) begin to = 1; done = 1; end
            @(posedge clk); #1;
        end
        s_valid = 2'b00; s_last = 1'b0; m_ready = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1; s_valid = 2'b11; s_data = 8'h5A; s_last = 1'b0; m_ready = 1'b1; sel = 0;
        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            sel = d;
            #1;
            n_tests++;
            if (o_vld !== 1'b1 || o_dat !== 8'h5A || o_last !== 1'b0 || o_srdy !== 1'b1) begin
                n_fail++;
                $display("FAIL reset_passthru dut%0d: vld=%b dat=%h last=%b rdy=%b, need 1 5a 0 1", d, o_vld, o_dat, o_last, o_srdy);
            end
        end
        @(posedge clk); #1;
        s_valid = 2'b00; rst = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            sel = d;
            #1;
            n_tests++;
            if (o_vld !== 1'b0 || o_last !== 1'b0 || o_srdy !== 1'b1) begin
                n_fail++;
                $display("FAIL reset_idle dut%0d: vld=%b last=%b rdy=%b, need 0 0 1", d, o_vld, o_last, o_srdy);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_check_vector();
        logic [7:0] ev [13] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
                               8'h26, 8'h39, 8'hF4, 8'hCB};
        bit to;
        for (int i = 0; i < 9; i++) tx_pay[i] = 8'h31 + 8'(i);
        rx_dat.delete(); rx_last.delete();
        run_frame(0, 9, 1'b0, 100000, to);
        n_tests++;
        if (to !== 1'b0 || rx_dat.size() !== 13) begin
            n_fail++;
            $display("FAIL check_len: got %0d bytes (timeout=%b), need 13", rx_dat.size(), to);
        end else begin
            for (int i = 0; i < 13; i++) begin
                n_tests++;
                if (rx_dat[i] !== ev[i] || rx_last[i] !== (i == 12)) begin
                    n_fail++;
                    $display("FAIL check_byte[%0d]: got %h last=%b, need %h last=%b", i, rx_dat[i], rx_last[i], ev[i], (i == 12));
                end
            end
        end
    endtask

    task automatic test_pad();
        int lens [4] = '{14, 1, 59, 60};
        int len, tot, bad;
        bit to;
        logic [31:0] exp_fcs, got;
        foreach (lens[t]) begin
            len = lens[t];
            tot = (len < 60) ? 60 : len;
            for (int i = 0; i < len; i++) tx_pay[i] = 8'(i * 7 + 3);
            rx_dat.delete(); rx_last.delete();
            run_frame(1, len, 1'b0, 100000, to);
            exp_fcs = model_fcs(len, tot);
            n_tests++;
            if (to !== 1'b0 || rx_dat.size() !== tot + 4) begin
                n_fail++;
                $display("FAIL pad_len len=%0d: got %0d bytes (timeout=%b), need %0d", len, rx_dat.size(), to, tot + 4);
            end else begin
                bad = 0;
                for (int i = 0; i < tot; i++)
                    if (rx_dat[i] !== ((i < len) ? tx_pay[i] : 8'h00) || rx_last[i] !== 1'b0) bad++;
                n_tests++;
                if (bad !== 0) begin
                    n_fail++;
                    $display("FAIL pad_data len=%0d: %0d bad bytes, need 0", len, bad);
                end
                got = {rx_dat[tot+3], rx_dat[tot+2], rx_dat[tot+1], rx_dat[tot]};
                n_tests++;
                if (got !== exp_fcs || rx_last[tot+3] !== 1'b1 || rx_last[tot+2] !== 1'b0) begin
                    n_fail++;
                    $display("FAIL pad_fcs len=%0d: got %h last=%b, need %h last=1", len, got, rx_last[tot+3], exp_fcs);
                end
            end
        end
    endtask

    task automatic test_single_byte();
        bit to;
        logic [31:0] got, exp_fcs;
        tx_pay[0] = 8'hAB;
        rx_dat.delete(); rx_last.delete();
        run_frame(0, 1, 1'b0, 100000, to);
        exp_fcs = model_fcs(1, 1);
        n_tests++;
        if (to !== 1'b0 || rx_dat.size() !== 5) begin
            n_fail++;
            $display("FAIL single_len: got %0d bytes, need 5", rx_dat.size());
        end else begin
            got = {rx_dat[4], rx_dat[3], rx_dat[2], rx_dat[1]};
            n_tests++;
            if (rx_dat[0] !== 8'hAB || got !== exp_fcs || rx_last[4] !== 1'b1) begin
                n_fail++;
                $display("FAIL single_frame: got %h/%h last=%b, need ab/%h last=1", rx_dat[0], got, rx_last[4], exp_fcs);
            end
        end
    endtask

    task automatic test_back_to_back();
        int lens [2] = '{20, 11};
        bit to;
        logic [31:0] got, exp_fcs;
        for (int f = 0; f < 2; f++) begin
            for (int i = 0; i < lens[f]; i++) tx_pay[i] = 8'(i * 13 + f * 91 + 5);
            rx_dat.delete(); rx_last.delete();
            run_frame(0, lens[f], 1'b0, 100000, to);
            exp_fcs = model_fcs(lens[f], lens[f]);
            n_tests++;
            if (to !== 1'b0 || rx_dat.size() !== lens[f] + 4) begin
                n_fail++;
                $display("FAIL b2b_len frame%0d: got %0d bytes, need %0d", f, rx_dat.size(), lens[f] + 4);
            end else begin
                got = {rx_dat[lens[f]+3], rx_dat[lens[f]+2], rx_dat[lens[f]+1], rx_dat[lens[f]]};
                n_tests++;
                if (got !== exp_fcs) begin
                    n_fail++;
                    $display("FAIL b2b_fcs frame%0d: got %h, need %h", f, got, exp_fcs);
                end
            end
        end
    endtask

    task automatic test_random();
        int len, bad;
        bit to;
        logic [31:0] c, got, exp_fcs;
        for (int f = 0; f < 3; f++) begin
            len = (f == 0) ? 64 : $urandom_range(1518, 64);
            for (int i = 0; i < len; i++) tx_pay[i] = 8'($urandom);
            rx_dat.delete(); rx_last.delete();
            run_frame(1, len, 1'b1, 100000, to);
            exp_fcs = model_fcs(len, len);
            n_tests++;
            if (to !== 1'b0 || rx_dat.size() !== len + 4) begin
                n_fail++;
                $display("FAIL rand_len len=%0d: got %0d bytes (timeout=%b), need %0d", len, rx_dat.size(), to, len + 4);
            end else begin
                bad = 0;
                for (int i = 0; i < len; i++) if (rx_dat[i] !== tx_pay[i]) bad++;
                got = {rx_dat[len+3], rx_dat[len+2], rx_dat[len+1], rx_dat[len]};
                n_tests++;
                if (bad !== 0 || got !== exp_fcs) begin
                    n_fail++;
                    $display("FAIL rand_frame len=%0d: %0d bad bytes fcs=%h, need 0 and %h", len, bad, got, exp_fcs);
                end
                // 0xDEBB20E3 is the bit-reversed form of residue 0xC704DD7B.
                c = 32'hFFFF_FFFF;
                foreach (rx_dat[i]) c = crc_step(c, rx_dat[i]);
                n_tests++;
                if (c !== 32'hDEBB_20E3) begin
                    n_fail++;
                    $display("FAIL rand_residue len=%0d: got %h, need debb20e3", len, c);
                end
            end
        end
    endtask

    task automatic test_stall();
        bit to;
        int cyc;
        for (int i = 0; i < 9; i++) tx_pay[i] = 8'h31 + 8'(i);
        rx_dat.delete(); rx_last.delete();
        run_frame(0, 9, 1'b0, 10, to);
        m_ready = 1'b0; s_valid = 2'b01; s_data = 8'h77;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            n_tests++;
            if (o_vld !== 1'b1 || o_dat !== 8'h39 || o_srdy !== 1'b0 || o_last !== 1'b0) begin
                n_fail++;
                $display("FAIL stall_hold cyc%0d: vld=%b dat=%h rdy=%b last=%b, need 1 39 0 0", c, o_vld, o_dat, o_srdy, o_last);
            end
            @(posedge clk); #1;
        end
        m_ready = 1'b1; s_valid = 2'b00;
        cyc = 0;
        while (cyc < 10) begin
            @(negedge clk);
            if (o_vld && m_ready) begin rx_dat.push_back(o_dat); rx_last.push_back(o_last); end
            @(posedge clk); #1;
            cyc = (rx_dat.size() > 0 && rx_last[rx_last.size()-1]) ? 10 : cyc + 1;
        end
        n_tests++;
        if (to !== 1'b0 || rx_dat.size() !== 13) begin
            n_fail++;
            $display("FAIL stall_len: got %0d bytes, need 13", rx_dat.size());
        end else if ({rx_dat[9], rx_dat[10], rx_dat[11], rx_dat[12]} !== 32'h2639_F4CB || rx_last[12] !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_fcs: got %h%h%h%h last=%b, need 2639f4cb last=1", rx_dat[9], rx_dat[10], rx_dat[11], rx_dat[12], rx_last[12]);
        end
    endtask

    task automatic test_reset_mid_pad();
        bit to;
        logic [31:0] got, exp_fcs;
        for (int i = 0; i < 14; i++) tx_pay[i] = 8'hC0 + 8'(i);
        rx_dat.delete(); rx_last.delete();
        run_frame(1, 14, 1'b0, 20, to);
        rst = 1'b1; m_ready = 1'b1; s_valid = 2'b00;
        @(negedge clk);
        n_tests++;
        if (to !== 1'b0 || o_vld !== 1'b0 || o_last !== 1'b0) begin
            n_fail++;
            $display("FAIL midpad_rst: vld=%b last=%b timeout=%b, need 0 0 0", o_vld, o_last, to);
        end
        @(posedge clk); #1;
        rst = 1'b0; m_ready = 1'b0; s_valid = 2'b10; s_data = 8'hA5;
        @(negedge clk);
        n_tests++;
        if (o_vld !== 1'b1 || o_dat !== 8'hA5 || o_last !== 1'b0 || o_srdy !== 1'b0) begin
            n_fail++;
            $display("FAIL midpad_idle: vld=%b dat=%h last=%b rdy=%b, need 1 a5 0 0", o_vld, o_dat, o_last, o_srdy);
        end
        @(posedge clk); #1;
        s_valid = 2'b00; m_ready = 1'b1;
        for (int i = 0; i < 9; i++) tx_pay[i] = 8'h31 + 8'(i);
        rx_dat.delete(); rx_last.delete();
        run_frame(1, 9, 1'b0, 100000, to);
        exp_fcs = model_fcs(9, 60);
        n_tests++;
        if (to !== 1'b0 || rx_dat.size() !== 64) begin
            n_fail++;
            $display("FAIL midpad_next_len: got %0d bytes, need 64", rx_dat.size());
        end else begin
            got = {rx_dat[63], rx_dat[62], rx_dat[61], rx_dat[60]};
            n_tests++;
            if (got !== exp_fcs || rx_dat[0] !== 8'h31) begin
                n_fail++;
                $display("FAIL midpad_next_fcs: got %h first=%h, need %h first=31", got, rx_dat[0], exp_fcs);
            end
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_check_vector();
        test_pad();
        test_single_byte();
        test_back_to_back();
        test_stall();
        test_reset_mid_pad();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
